// File: rtl/key_debounce_pkg.sv
// Shared constants, sizing helpers and types for the key_debounce block.
package key_debounce_pkg;

  localparam int CLK_HZ                  = 27_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int REPEAT_DELAY_DEFAULT    = CLK_HZ / 2;
  localparam int REPEAT_PERIOD_DEFAULT   = CLK_HZ / 10;

  // Kind of accepted level change on one channel in the current cycle.
  typedef enum logic [1:0] {
    EDGE_NONE    = 2'd0,
    EDGE_PRESS   = 2'd1,
    EDGE_RELEASE = 2'd2
  } edge_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A counter that must reach n-1 never needs fewer than one bit.
  function automatic int cnt_width(input int n);
    return max_int(1, $clog2(n));
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: 2-flop synchroniser, stability counter and registered edge pulses.
// With KEY_DEBOUNCE_AUTOREPEAT_EN defined, a hold counter adds repeat press pulses.
module key_debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEFAULT
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_DEFAULT
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  edge_e         edge_s;
  logic          repeat_s;

  // Synchroniser shift and debounce counter; the counter only ever counts up to CNT_LAST.
  always_comb begin
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = {CW{1'b0}};
    edge_s   = EDGE_NONE;
    if (sync2_q == stable_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = {CW{1'b0}};
      edge_s   = sync2_q ? EDGE_PRESS : EDGE_RELEASE;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int              HW         = cnt_width(max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES) + 1);
  localparam logic [HW-1:0]   HOLD_FIRST = HW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_NEXT  = HW'(REPEAT_PERIOD_CYCLES - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          rpt_q, rpt_d;
  logic [HW-1:0] hold_target_s;

  // Hold timer: restarts on every accepted change, so a repeat never lands on a press or release.
  always_comb begin
    hold_d        = hold_q;
    rpt_d         = rpt_q;
    repeat_s      = 1'b0;
    hold_target_s = rpt_q ? HOLD_NEXT : HOLD_FIRST;
    if ((edge_s != EDGE_NONE) || !stable_q) begin
      hold_d = {HW{1'b0}};
      rpt_d  = 1'b0;
    end else if (hold_q == hold_target_s) begin
      repeat_s = 1'b1;
      hold_d   = {HW{1'b0}};
      rpt_d    = 1'b1;
    end else begin
      hold_d = hold_q + HW'(1);
    end
  end

  // Hold timer state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q <= {HW{1'b0}};
      rpt_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rpt_q  <= rpt_d;
    end
  end
`else
  assign repeat_s = 1'b0;
`endif

  // Output pulses are registered alongside the level they belong to.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    case (edge_s)
      EDGE_PRESS:   press_d   = 1'b1;
      EDGE_RELEASE: release_d = 1'b1;
      EDGE_NONE:    press_d   = repeat_s;
      default: begin
        press_d   = 1'b0;
        release_d = 1'b0;
      end
    endcase
  end

  // Channel state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_state   = stable_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debounced level plus press/release pulses for N_KEYS independent push buttons.
// Optional auto-repeat of key_press is enabled by defining KEY_DEBOUNCE_AUTOREPEAT_EN.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS               = 8,
  parameter int DEBOUNCE_CYCLES      = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  // Refuse to elaborate with timing values the channels cannot honour.
  if ((DEBOUNCE_CYCLES < 2) || (REPEAT_DELAY_CYCLES < 1) || (REPEAT_PERIOD_CYCLES < 1)) begin : g_bad_cfg
    $error("key_debounce: illegal timing parameters");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES)
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
`endif
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .key_raw     (key_raw[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Debounces and synchronises raw push-button inputs (board keys or TM1638 keys) into clean level and single-cycle edge outputs.
- Produces the conditioned signals that downstream lab logic (LED drivers, counters, FSMs) consumes in place of raw `key` bits.
- Sits directly between the board wrapper's `key` bus and `hackathon_top` user logic.
- One independent channel per key; all channels share one clock domain.

Parameters:
- N_KEYS, 8, number of key channels.
- DEBOUNCE_CYCLES, 270000, consecutive stable cycles required to accept a new level (10 ms at 27 MHz); legal range ≥ 2.
- REPEAT_DELAY_CYCLES, 13500000, hold time before the first auto-repeat pulse (0.5 s); used only with the optional feature.
- REPEAT_PERIOD_CYCLES, 2700000, interval between subsequent auto-repeat pulses (0.1 s); used only with the optional feature.

Ports:
- clock, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- key_raw, input, N_KEYS, raw asynchronous key levels; 1 = pressed.
- key_state, output, N_KEYS, debounced level; 1 = pressed.
- key_press, output, N_KEYS, one-cycle pulse per accepted 0→1 transition (plus repeats when the optional feature is enabled).
- key_release, output, N_KEYS, one-cycle pulse per accepted 1→0 transition.

Behaviour:
- Reset (asynchronous, active-high):
  - Synchroniser flops, stable level, counters, key_state, key_press and key_release all go to 0 immediately.
  - Reset is honoured mid-count; no pulse is emitted on reset deassertion, even if key_raw = 1.
- Synchroniser: 2-flop chain per bit; sync = second flop.
- Per channel, each cycle:
  - If sync == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync; cnt <= 0; pulse key_press (if sync = 1) or key_release (if sync = 0) in the same cycle that key_state changes.
  - Else: cnt <= cnt + 1.
- Counter sizing: cnt width = $clog2(DEBOUNCE_CYCLES). The counter saturates at the compare point and never wraps.
- Glitch rejection: any bounce back to the stable level before the count completes clears cnt. Bounces shorter than DEBOUNCE_CYCLES are never seen at the outputs.
- Latency: a clean raw edge reaches key_state after exactly DEBOUNCE_CYCLES+2 rising edges. key_press/key_release assert registered, aligned with the key_state change, for exactly 1 cycle.
- key_press and key_release are never both high on one channel in the same cycle.
- Channels are fully independent: simultaneous edges on several keys produce simultaneous pulses.
- All outputs are registered (no combinational path from key_raw).

Optional Feature:
- Macro: KEY_DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - Each channel has a hold counter sized $clog2(max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)+1).
  - While key_state = 1, the counter runs. An extra key_press pulse fires REPEAT_DELAY_CYCLES cycles after the accepted press pulse, then every REPEAT_PERIOD_CYCLES cycles.
  - The counter clears on release and on reset.
  - key_release is unaffected.
- Undefined:
  - No hold counter is instantiated.
  - key_press fires exactly once per accepted press.
  - REPEAT_* parameters are ignored.

Decomposition:
- Package key_debounce_pkg:
  - Function cnt_width(int n) returning max(1, $clog2(n)).
  - Default timing constants: CLK_HZ = 27_000_000, DEBOUNCE_MS = 10.
  - Localparam-derived DEBOUNCE_CYCLES default.
- Sub-module key_debounce_channel:
  - Single-bit synchroniser, counter, edge pulses, and the optional repeat logic.
  - Instantiated N_KEYS times via generate in key_debounce.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=3, N_KEYS=8):
- Clean press: key_raw[0] 0→1 held → key_state[0]=1 and key_press[0]=1 for one cycle at edge 6 after the change; all other bits stay 0.
- Bounce reject: key_raw[1] toggles 1,0,1,0 each cycle, then returns to 0 → key_state[1], key_press[1] and key_release[1] stay 0 throughout.
- Release: key_raw[0] 1→0 after an accepted press → key_release[0] pulses once at edge 6; key_state[0]=0; no key_press.
- Simultaneous keys: key_raw = 8'hA5 from all-zero → key_press = 8'hA5 for exactly one cycle at edge 6; key_state = 8'hA5.
- Reset mid-count: key_raw[2]=1 for 3 cycles, then assert reset → all outputs 0 at once. After deassert with key_raw[2] still 1 → exactly one press pulse 6 edges later.
- Auto-repeat (macro defined): hold key_raw[3]=1 for 30 cycles → key_press[3] pulses at acceptance, +10, +13, +16, …; one key_release on let-go. Macro undefined → single pulse only.
